// File: rtl/pll_lock_seq_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings
// (PLL primitive, clock gate, DDR init logic).
interface pll_lock_seq_if;
  // restart_req is a request without a ready: a one-cycle pulse that the
  // sequencer always accepts on the clock edge where it is sampled high.
  logic       pll_lock;
  logic       restart_req;
  logic       pll_rst;
  logic       clkout0_gate;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] dbg_state;

  modport slave (
    input  pll_lock,
    input  restart_req,
    output pll_rst,
    output clkout0_gate,
    output ready,
    output fail,
    output lock_lost,
    output retry_cnt,
    output dbg_state
  );

  modport master (
    output pll_lock,
    output restart_req,
    input  pll_rst,
    input  clkout0_gate,
    input  ready,
    input  fail,
    input  lock_lost,
    input  retry_cnt,
    input  dbg_state
  );
endinterface

// File: rtl/pll_lock_seq.sv
// Reset/lock sequencer for the DDR3 50->400 MHz PLL: holds PLL reset, waits for
// lock with timeout and bounded retries, debounces lock, then gates CLKOUT0 on.
module pll_lock_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 256,
  parameter int GATE_DELAY   = 8,
  parameter int MAX_RETRY    = 3
) (
  input logic            clkin1,
  input logic            rst,
  pll_lock_seq_if.slave  bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (LOCK_STABLE > GATE_DELAY) ? LOCK_STABLE : GATE_DELAY;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_TOP     = CW'(CNT_MAX);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_DELAY - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_GATE_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
  localparam logic [2:0] S_FAIL       = 3'd5;

  logic          lock_meta;
  logic          lock_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    retry_cnt;
  logic [3:0]    retry_nxt;
  logic          lock_lost_nxt;

  logic pll_rst_q, gate_q, ready_q, fail_q, lock_lost_q;
  logic pll_rst_nxt, gate_nxt, ready_nxt, fail_nxt;

  // pll_lock comes from the PLL's own clock domain.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt     = state;
    retry_nxt     = retry_cnt;
    lock_lost_nxt = 1'b0;
    if (bus.restart_req) begin
      state_nxt = S_RESET_HOLD;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TO_LAST) begin
            if (retry_cnt >= RETRY_MAX) begin
              state_nxt = S_FAIL;
            end else begin
              state_nxt = S_RESET_HOLD;
              retry_nxt = retry_cnt + 4'd1;
            end
          end
        end
        S_STABLE: begin
          // A dropout sends us back to wait with a fresh timeout, not a retry.
          if (!lock_s) state_nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = S_GATE_WAIT;
        end
        S_GATE_WAIT: begin
          if (!lock_s) begin
            state_nxt = S_RESET_HOLD;
          end else if (cnt == GATE_LAST) begin
            state_nxt = S_RUN;
            retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_nxt     = S_RESET_HOLD;
            lock_lost_nxt = 1'b1;
          end
        end
        S_FAIL: begin
          state_nxt = S_FAIL;
        end
        default: begin
          state_nxt = S_RESET_HOLD;
        end
      endcase
    end
  end

  // Counter restarts on any state change and on restart_req (even in RESET_HOLD).
  always_comb begin
    if (bus.restart_req || (state_nxt != state)) cnt_nxt = '0;
    else if (cnt == CNT_TOP)                     cnt_nxt = cnt;
    else                                         cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    pll_rst_nxt = 1'b0;
    gate_nxt    = 1'b0;
    ready_nxt   = 1'b0;
    fail_nxt    = 1'b0;
    case (state_nxt)
      S_RESET_HOLD: pll_rst_nxt = 1'b1;
      S_GATE_WAIT:  gate_nxt    = 1'b1;
      S_RUN: begin
        gate_nxt  = 1'b1;
        ready_nxt = 1'b1;
      end
      S_FAIL: begin
        pll_rst_nxt = 1'b1;
        fail_nxt    = 1'b1;
      end
      default: pll_rst_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      state       <= S_RESET_HOLD;
      cnt         <= '0;
      retry_cnt   <= 4'd0;
      pll_rst_q   <= 1'b1;
      gate_q      <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_cnt   <= retry_nxt;
      pll_rst_q   <= pll_rst_nxt;
      gate_q      <= gate_nxt;
      ready_q     <= ready_nxt;
      fail_q      <= fail_nxt;
      lock_lost_q <= lock_lost_nxt;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.clkout0_gate = gate_q;
  assign bus.ready        = ready_q;
  assign bus.fail         = fail_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.retry_cnt    = retry_cnt;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scenario bench for pll_lock_seq: expected latencies and output snapshots are
// queued when stimulus is applied and compared when the DUT reaches them.
module tb_pll_lock_seq;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_STABLE  = 256;
  localparam int GATE_DELAY   = 8;
  localparam int MAX_RETRY    = 3;
  localparam int BUDGET       = 2000;

  localparam int SIG_RST   = 0;
  localparam int SIG_GATE  = 1;
  localparam int SIG_READY = 2;
  localparam int SIG_FAIL  = 3;

  logic clk;
  logic rst;
  pll_lock_seq_if bus ();

  pll_lock_seq #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .GATE_DELAY  (GATE_DELAY),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clkin1(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "bench stopped by watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_RST:   return bus.pll_rst;
      SIG_GATE:  return bus.clkout0_gate;
      SIG_READY: return bus.ready;
      default:   return bus.fail;
    endcase
  endfunction

  // Ticks until the selected output equals val; n = BUDGET+1 if it never does.
  task automatic wait_sig(input int sel, input logic val, output int n);
    n = 0;
    while (sig(sel) !== val && n <= BUDGET) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] snap();
    return {20'd0, bus.pll_rst, bus.clkout0_gate, bus.ready, bus.fail,
            bus.lock_lost, bus.retry_cnt, bus.dbg_state};
  endfunction

  function automatic logic [31:0] mk(input logic r, input logic g, input logic rd,
                                     input logic f, input logic ll,
                                     input logic [3:0] rc, input logic [2:0] st);
    return {20'd0, r, g, rd, f, ll, rc, st};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    bus.restart_req = 1'b0;
    repeat (3) tick();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'd0, 3'd0));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL reset_state: got %h, expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_nominal();
    int n;
    rst = 1'b0;
    exp_q.push_back(32'(RST_CYCLES));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL nominal_rst_hold: got %0d, expected %0d", n, exp_v);
    end
    repeat (100 - RST_CYCLES) tick();
    bus.pll_lock = 1'b1;
    exp_q.push_back(32'(3 + LOCK_STABLE));
    wait_sig(SIG_GATE, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL nominal_gate_latency: got %0d, expected %0d", n, exp_v);
    end
    exp_q.push_back(32'(GATE_DELAY));
    wait_sig(SIG_READY, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL nominal_ready_delay: got %0d, expected %0d", n, exp_v);
    end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 4'd0, 3'd4));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL nominal_run_state: got %h, expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int lost;
    lost = 0;
    bus.pll_lock = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.lock_lost === 1'b1) lost++;
      if (i == 2) begin
        exp_q.push_back(mk(0, 1, 1, 0, 0, 4'd0, 3'd4));
        exp_v = exp_q.pop_front(); vec_cnt++;
        if (snap() !== exp_v) begin
          err_cnt++; $display("FAIL loss_too_early: got %h, expected %h", snap(), exp_v);
        end
      end
      if (i == 3) begin
        exp_q.push_back(mk(1, 0, 0, 0, 1, 4'd0, 3'd0));
        exp_v = exp_q.pop_front(); vec_cnt++;
        if (snap() !== exp_v) begin
          err_cnt++; $display("FAIL loss_response: got %h, expected %h", snap(), exp_v);
        end
      end
    end
    exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (lost !== int'(exp_v)) begin
      err_cnt++; $display("FAIL lock_lost_pulses: got %0d, expected %0d", lost, exp_v);
    end
    bus.pll_lock = 1'b1;
    exp_q.push_back(32'(RST_CYCLES + 1 + LOCK_STABLE + GATE_DELAY - 5));
    wait_sig(SIG_READY, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL relock_ready: got %0d, expected %0d", n, exp_v);
    end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 4'd0, 3'd4));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL relock_state: got %h, expected %h", snap(), exp_v);
    end
  endtask

  task automatic test_debounce();
    int n;
    int gate_hi;
    gate_hi = 0;
    bus.pll_lock = 1'b0;
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    exp_q.push_back(32'(RST_CYCLES));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL debounce_restart_hold: got %0d, expected %0d", n, exp_v);
    end
    bus.pll_lock = 1'b1;
    repeat (100) begin
      tick();
      if (bus.clkout0_gate !== 1'b0) gate_hi++;
    end
    bus.pll_lock = 1'b0;
    repeat (5) begin
      tick();
      if (bus.clkout0_gate !== 1'b0) gate_hi++;
    end
    bus.pll_lock = 1'b1;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (gate_hi !== int'(exp_v)) begin
      err_cnt++; $display("FAIL debounce_early_gate: got %0d, expected %0d", gate_hi, exp_v);
    end
    exp_q.push_back(32'(3 + LOCK_STABLE));
    wait_sig(SIG_GATE, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL debounce_gate_latency: got %0d, expected %0d", n, exp_v);
    end
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (bus.retry_cnt !== exp_v[3:0]) begin
      err_cnt++; $display("FAIL debounce_retry: got %0d, expected %0d", bus.retry_cnt, exp_v);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus.pll_lock = 1'b0;
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'd0, 3'd0));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL timeout_restart: got %h, expected %h", snap(), exp_v);
    end
    exp_q.push_back(32'(RST_CYCLES));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL timeout_first_hold: got %0d, expected %0d", n, exp_v);
    end
    for (int r = 1; r <= MAX_RETRY; r++) begin
      exp_q.push_back(32'(LOCK_TIMEOUT));
      exp_q.push_back(32'(r));
      exp_q.push_back(32'(RST_CYCLES));
      wait_sig(SIG_RST, 1'b1, n);
      exp_v = exp_q.pop_front(); vec_cnt++;
      if (n !== int'(exp_v)) begin
        err_cnt++; $display("FAIL timeout_wait%0d: got %0d, expected %0d", r, n, exp_v);
      end
      exp_v = exp_q.pop_front(); vec_cnt++;
      if (bus.retry_cnt !== exp_v[3:0]) begin
        err_cnt++; $display("FAIL retry_cnt%0d: got %0d, expected %0d", r, bus.retry_cnt, exp_v);
      end
      wait_sig(SIG_RST, 1'b0, n);
      exp_v = exp_q.pop_front(); vec_cnt++;
      if (n !== int'(exp_v)) begin
        err_cnt++; $display("FAIL retry_hold%0d: got %0d, expected %0d", r, n, exp_v);
      end
    end
    exp_q.push_back(32'(LOCK_TIMEOUT));
    wait_sig(SIG_FAIL, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL fail_wait: got %0d, expected %0d", n, exp_v);
    end
    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'(MAX_RETRY), 3'd5));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL fail_state: got %h, expected %h", snap(), exp_v);
    end
    repeat (50) tick();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 4'(MAX_RETRY), 3'd5));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL fail_sticky: got %h, expected %h", snap(), exp_v);
    end
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'd0, 3'd0));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL fail_restart: got %h, expected %h", snap(), exp_v);
    end
    exp_q.push_back(32'(RST_CYCLES));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL fail_restart_hold: got %0d, expected %0d", n, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    for (int r = 1; r <= MAX_RETRY; r++) begin
      wait_sig(SIG_RST, 1'b1, n);
      wait_sig(SIG_RST, 1'b0, n);
    end
    exp_q.push_back(32'(MAX_RETRY));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (bus.retry_cnt !== exp_v[3:0]) begin
      err_cnt++; $display("FAIL sim_retry_max: got %0d, expected %0d", bus.retry_cnt, exp_v);
    end
    repeat (LOCK_TIMEOUT - 1) tick();
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'd0, 3'd0));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL restart_vs_timeout: got %h, expected %h", snap(), exp_v);
    end
    exp_q.push_back(32'(RST_CYCLES));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL sim_restart_hold: got %0d, expected %0d", n, exp_v);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bus.pll_lock = 1'b1;
    exp_q.push_back(32'(3 + LOCK_STABLE));
    wait_sig(SIG_GATE, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL async_pre_gate: got %0d, expected %0d", n, exp_v);
    end
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 4'd0, 3'd0));
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (snap() !== exp_v) begin
      err_cnt++; $display("FAIL async_reset_now: got %h, expected %h", snap(), exp_v);
    end
    tick();
    rst = 1'b0;
    exp_q.push_back(32'(RST_CYCLES));
    exp_q.push_back(32'(1 + LOCK_STABLE));
    exp_q.push_back(32'(GATE_DELAY));
    wait_sig(SIG_RST, 1'b0, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL async_rst_hold: got %0d, expected %0d", n, exp_v);
    end
    wait_sig(SIG_GATE, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL async_regate: got %0d, expected %0d", n, exp_v);
    end
    wait_sig(SIG_READY, 1'b1, n);
    exp_v = exp_q.pop_front(); vec_cnt++;
    if (n !== int'(exp_v)) begin
      err_cnt++; $display("FAIL async_ready: got %0d, expected %0d", n, exp_v);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_debounce();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Reset/lock sequencer for the DDR3 core's 50→400 MHz PLL. It drives the PLL reset, waits for lock with a timeout, debounces lock, enables the gated CLKOUT0 (the 400 MHz DDR clock), and reports ready or fail to the DDR init logic. On timeout it retries up to a bounded count, and it re-runs the sequence on lock loss or on request. It runs on the 50 MHz PLL reference clock, upstream of the PLL instance.

## Interface
Parameters:
- RST_CYCLES, 16 — cycles pll_rst is held high per attempt (≥2)
- LOCK_TIMEOUT, 50000 — cycles to wait for synced lock per attempt (1 ms @ 50 MHz)
- LOCK_STABLE, 256 — consecutive synced-lock-high cycles required before gating
- GATE_DELAY, 8 — cycles between clkout0_gate rise and ready rise
- MAX_RETRY, 3 — timeout retries allowed before FAIL (0..15)

Ports:
- clkin1  in  1  50 MHz reference clock; also feeds the PLL
- rst  in  1  asynchronous, active-high reset
- pll_lock  in  1  PLL lock, asynchronous to clkin1
- restart_req  in  1  one-cycle pulse: restart the full sequence
- pll_rst  out  1  PLL reset, active-high
- clkout0_gate  out  1  CLKOUT0 gate enable, high = clock runs
- ready  out  1  PLL locked, stable, and clock gated on
- fail  out  1  retries exhausted; sticky until restart_req or rst
- lock_lost  out  1  one-cycle pulse when lock drops in RUN
- retry_cnt  out  4  timeout retries used in the current sequence

## Operation
- pll_lock passes through a 2-flop synchronizer to give lock_s. All decisions use lock_s.
- One shared counter cnt. Its width is clog2(max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, GATE_DELAY)+1). It clears on every state change.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- States and outputs (pll_rst / gate / ready / fail):
  - RESET_HOLD: 1/0/0/0
  - WAIT_LOCK: 0/0/0/0
  - STABLE: 0/0/0/0
  - GATE_WAIT: 0/1/0/0
  - RUN: 0/1/1/0
  - FAIL: 1/0/0/1
- RESET_HOLD → WAIT_LOCK when cnt == RST_CYCLES-1.
- WAIT_LOCK:
  - lock_s=1 → STABLE.
  - Otherwise, at cnt == LOCK_TIMEOUT-1: if retry_cnt == MAX_RETRY → FAIL; else retry_cnt+1 and → RESET_HOLD.
- STABLE:
  - lock_s=0 → WAIT_LOCK. The timeout restarts; this is not a retry.
  - cnt == LOCK_STABLE-1 with lock_s=1 → GATE_WAIT.
- GATE_WAIT:
  - lock_s=0 → RESET_HOLD, with no lock_lost pulse.
  - cnt == GATE_DELAY-1 → RUN. retry_cnt clears on entry to RUN.
- RUN: lock_s=0 → RESET_HOLD, with lock_lost=1 for exactly one cycle. retry_cnt stays 0.
- FAIL: held until restart_req.
- restart_req, in any state: → RESET_HOLD, retry_cnt=0, cnt=0. It has priority over every lock or timeout event in the same cycle. A restart_req during RESET_HOLD restarts the hold count.
- retry_cnt saturates at MAX_RETRY. It never wraps.

## Timing
- rst asserted: state=RESET_HOLD, pll_rst=1, and clkout0_gate, ready, fail, lock_lost, retry_cnt and cnt all 0. Synchronizer flops are 0.
- First rising edge after rst deasserts begins the count. pll_rst stays high for exactly RST_CYCLES clkin1 cycles.
- Lock-to-gate latency: pll_lock rise → clkout0_gate rise = 2 (sync) + 1 (WAIT_LOCK→STABLE) + LOCK_STABLE cycles.
- ready rises exactly GATE_DELAY cycles after clkout0_gate.
- Lock loss in RUN: clkout0_gate, ready and pll_rst change 3 cycles after pll_lock falls (2 sync + 1 register). lock_lost pulses in that same cycle.
- Lock glitches shorter than 1 cycle may be missed by the synchronizer. This is acceptable.
- rst asserted mid-operation: outputs take reset values immediately, without waiting for a clock edge.

## Test plan
- Nominal: defaults, pll_lock rises 100 cycles after rst release and stays high → pll_rst high for 16 cycles; clkout0_gate rises 2+1+256 cycles after lock; ready rises 8 cycles later; retry_cnt=0.
- Timeout retries: LOCK_TIMEOUT=100, pll_lock held 0 → three RESET_HOLD re-entries with retry_cnt=1,2,3, then FAIL with fail=1 and pll_rst=1 held. restart_req → fail=0, retry_cnt=0, new 16-cycle reset.
- Debounce: pll_lock high for 100 cycles, low for 5, then high → no clkout0_gate until 256 consecutive synced-high cycles; retry_cnt unchanged.
- Lock loss in RUN: drop pll_lock → exactly one lock_lost pulse; gate and ready low and pll_rst high 3 cycles later. Relock gives ready again with retry_cnt=0.
- Simultaneous events: restart_req in the same cycle as WAIT_LOCK timeout at retry_cnt=MAX_RETRY → RESET_HOLD, not FAIL; retry_cnt=0.
- Async reset: assert rst mid-GATE_WAIT between clock edges → clkout0_gate=0 and pll_rst=1 immediately; sequence restarts from RESET_HOLD.
